// File: rtl/tinytpu_pkg.sv
// Shared parameter defaults and state encoding for the tinytpu operand path.
package tinytpu_pkg;

    localparam int unsigned TT_D_W  = 8;
    localparam int unsigned TT_N    = 2;
    localparam int unsigned TT_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } loader_state_t;

endpackage

// File: rtl/tinytpu_shift_reg.sv
// Serial-in/parallel-out matrix register with enable and synchronous clear.
// Bits shift in at the LSB. The stream arrives element 0 first, MSB first,
// so after a full load element 0 sits in the top slot of the shift register.
// The element slots are therefore presented in reversed order on dout,
// which places element k at dout[k*D_W +: D_W].
module tinytpu_shift_reg #(
    parameter int unsigned D_W  = 8,
    parameter int unsigned WORD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  din,
    output logic [WORD*D_W-1:0]   dout
);

    localparam int unsigned W = WORD * D_W;

    logic [W-1:0] sh;

    // Shift one bit per enabled cycle; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else if (clr) begin
            sh <= '0;
        end else if (en) begin
            sh <= {sh[W-2:0], din};
        end
    end

    // Reverse element order so element k lands at [k*D_W +: D_W].
    for (genvar k = 0; k < WORD; k++) begin : g_elem
        assign dout[k*D_W +: D_W] = sh[(WORD-1-k)*D_W +: D_W];
    end

endmodule

// File: rtl/tinytpu_operand_loader.sv
// Operand loader: assembles X and Y matrices from two serial bit streams
// and hands them to the systolic array with a valid/ready handshake.
module tinytpu_operand_loader
    import tinytpu_pkg::*;
#(
    parameter int unsigned D_W  = TT_D_W,
    parameter int unsigned N    = TT_N,
    parameter int unsigned WORD = TT_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_in_x,
    input  logic                  data_in_y,
    input  logic                  load_en,
    input  logic                  init,
    input  logic                  mat_ready,
    output logic [WORD*D_W-1:0]   mat_x,
    output logic [WORD*D_W-1:0]   mat_y,
    output logic                  mat_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned BITS  = WORD * D_W;
    localparam int unsigned CNT_W = $clog2(BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

    // Reject parameter sets where the matrix does not match the array size.
    if (WORD != N * N) begin : g_word_check
        $error("tinytpu_operand_loader: WORD must equal N*N");
    end

    loader_state_t    state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             overrun_next;
    logic             valid_next;
    logic             busy_next;
    logic             capture;
    logic             clear;

    // State, counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            overrun   <= 1'b0;
            mat_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            overrun   <= overrun_next;
            mat_valid <= valid_next;
            busy      <= busy_next;
        end
    end

    // Next-state, capture strobes and next flag values; init beats everything.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        overrun_next = overrun;
        capture      = 1'b0;
        clear        = 1'b0;

        if (init) begin
            state_next   = ST_LOAD;
            cnt_next     = '0;
            overrun_next = 1'b0;
            clear        = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Stray load_en and mat_ready are ignored here.
                end
                ST_LOAD: begin
                    if (load_en) begin
                        capture = 1'b1;
                        if (cnt == LAST_BIT) begin
                            state_next = ST_FULL;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (load_en) begin
                        overrun_next = 1'b1;
                    end
                    if (mat_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        valid_next = (state_next == ST_FULL);
        busy_next  = (state_next == ST_LOAD);
    end

    // X matrix register.
    tinytpu_shift_reg #(
        .D_W  (D_W),
        .WORD (WORD)
    ) u_shift_x (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .en    (capture),
        .din   (data_in_x),
        .dout  (mat_x)
    );

    // Y matrix register.
    tinytpu_shift_reg #(
        .D_W  (D_W),
        .WORD (WORD)
    ) u_shift_y (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .en    (capture),
        .din   (data_in_y),
        .dout  (mat_y)
    );

endmodule

// File: tb/tb_tinytpu_operand_loader.sv
// Directed bench for tinytpu_operand_loader with an expected-matrix queue.
module tb_tinytpu_operand_loader;
    import tinytpu_pkg::*;

    localparam int unsigned D_W  = 8;
    localparam int unsigned N    = 2;
    localparam int unsigned WORD = 4;
    localparam int unsigned BITS = WORD * D_W;

    typedef struct packed {
        logic [BITS-1:0] x;
        logic [BITS-1:0] y;
    } mat_pair_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            data_in_x;
    logic            data_in_y;
    logic            load_en;
    logic            init;
    logic            mat_ready;
    logic [BITS-1:0] mat_x;
    logic [BITS-1:0] mat_y;
    logic            mat_valid;
    logic            busy;
    logic            overrun;

    int errors = 0;
    int checks = 0;
    mat_pair_t exp_q[$];

    tinytpu_operand_loader #(
        .D_W  (D_W),
        .N    (N),
        .WORD (WORD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in_x (data_in_x),
        .data_in_y (data_in_y),
        .load_en   (load_en),
        .init      (init),
        .mat_ready (mat_ready),
        .mat_x     (mat_x),
        .mat_y     (mat_y),
        .mat_valid (mat_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream bit i: element 0 first, MSB first within each element.
    function automatic logic stream_bit(input logic [BITS-1:0] v, input int i);
        int k;
        int j;
        k = i / D_W;
        j = i % D_W;
        return v[k*D_W + (D_W - 1 - j)];
    endfunction

    task automatic pop_and_compare(input string tag);
        mat_pair_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 64'(0), 64'(1));
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_mat_x"}, 64'(mat_x), 64'(e.x));
            chk({tag, "_mat_y"}, 64'(mat_y), 64'(e.y));
        end
    endtask

    // Feed bits [first, last] of a load; max_gap > 0 inserts idle cycles before each bit.
    task automatic feed_bits(input logic [BITS-1:0] xv, input logic [BITS-1:0] yv,
                             input int first, input int last, input int max_gap);
        for (int i = first; i <= last; i++) begin
            if (max_gap > 0 && i != first) begin
                load_en = 1'b0;
                repeat ($urandom_range(max_gap, 1)) tick();
            end
            data_in_x = stream_bit(xv, i);
            data_in_y = stream_bit(yv, i);
            load_en   = 1'b1;
            tick();
        end
        load_en = 1'b0;
    endtask

    // Full load with exact valid-timing check around the final bit.
    task automatic load_and_check(input string tag, input logic [BITS-1:0] xv,
                                  input logic [BITS-1:0] yv, input int max_gap);
        mat_pair_t e;
        feed_bits(xv, yv, 0, int'(BITS) - 2, max_gap);
        if (max_gap > 0) begin
            repeat ($urandom_range(max_gap, 1)) tick();
        end
        chk({tag, "_valid_before_last"}, 64'(mat_valid), 64'(0));
        chk({tag, "_busy_before_last"}, 64'(busy), 64'(1));
        e.x = xv;
        e.y = yv;
        exp_q.push_back(e);
        feed_bits(xv, yv, int'(BITS) - 1, int'(BITS) - 1, 0);
        chk({tag, "_valid_after_last"}, 64'(mat_valid), 64'(1));
        chk({tag, "_busy_after_last"}, 64'(busy), 64'(0));
        if (mat_valid === 1'b1) begin
            pop_and_compare(tag);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    initial begin
        logic [BITS-1:0] hold_x;
        logic [BITS-1:0] hold_y;
        logic [BITS-1:0] x0;
        logic [BITS-1:0] y0;
        x0 = 32'h0403_0201;
        y0 = 32'h0807_0605;

        rst_n     = 1'b0;
        data_in_x = 1'b0;
        data_in_y = 1'b0;
        load_en   = 1'b0;
        init      = 1'b0;
        mat_ready = 1'b0;
        #2;
        chk("reset_mat_x", 64'(mat_x), 64'(0));
        chk("reset_mat_y", 64'(mat_y), 64'(0));
        chk("reset_valid", 64'(mat_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_overrun", 64'(overrun), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // load_en and mat_ready in IDLE are ignored
        load_en   = 1'b1;
        mat_ready = 1'b1;
        data_in_x = 1'b1;
        data_in_y = 1'b1;
        repeat (3) tick();
        load_en   = 1'b0;
        mat_ready = 1'b0;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_overrun", 64'(overrun), 64'(0));
        chk("idle_mat_x", 64'(mat_x), 64'(0));

        // init starts a load
        pulse_init();
        chk("init_busy", 64'(busy), 64'(1));
        chk("init_cnt", 64'(dut.cnt), 64'(0));

        // contiguous load
        load_and_check("contig", x0, y0, 0);

        // FULL held for 10 cycles with mat_ready low
        hold_x = mat_x;
        hold_y = mat_y;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_mat_x", 64'(mat_x), 64'(hold_x));
            chk("hold_mat_y", 64'(mat_y), 64'(hold_y));
            chk("hold_valid", 64'(mat_valid), 64'(1));
        end
        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
        chk("hs_valid", 64'(mat_valid), 64'(0));
        chk("hs_state", 64'(dut.state), 64'(ST_IDLE));
        chk("hs_retain_x", 64'(mat_x), 64'(x0));
        chk("hs_retain_y", 64'(mat_y), 64'(y0));

        // gapped load gives the same matrices
        pulse_init();
        load_and_check("gapped", x0, y0, 3);

        // load_en in FULL raises overrun without touching data
        load_en   = 1'b1;
        data_in_x = 1'b1;
        data_in_y = 1'b0;
        repeat (3) tick();
        load_en = 1'b0;
        chk("ovr_flag", 64'(overrun), 64'(1));
        chk("ovr_mat_x", 64'(mat_x), 64'(x0));
        chk("ovr_mat_y", 64'(mat_y), 64'(y0));
        chk("ovr_valid", 64'(mat_valid), 64'(1));
        tick();
        chk("ovr_sticky", 64'(overrun), 64'(1));
        pulse_init();
        chk("ovr_init_clear", 64'(overrun), 64'(0));
        chk("ovr_init_valid", 64'(mat_valid), 64'(0));
        chk("ovr_init_mat_x", 64'(mat_x), 64'(0));

        // init beats load_en after 17 bits
        feed_bits(x0, y0, 0, 16, 0);
        chk("part_cnt", 64'(dut.cnt), 64'(17));
        init      = 1'b1;
        load_en   = 1'b1;
        data_in_x = 1'b1;
        data_in_y = 1'b1;
        tick();
        init    = 1'b0;
        load_en = 1'b0;
        chk("init_win_cnt", 64'(dut.cnt), 64'(0));
        chk("init_win_mat_x", 64'(mat_x), 64'(0));
        chk("init_win_mat_y", 64'(mat_y), 64'(0));
        chk("init_win_busy", 64'(busy), 64'(1));
        load_and_check("reload", 32'hA5C3_7E81, 32'h1234_5678, 0);
        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
        chk("reload_hs_valid", 64'(mat_valid), 64'(0));

        // asynchronous reset mid-load
        pulse_init();
        feed_bits(x0, y0, 0, 9, 0);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mat_x", 64'(mat_x), 64'(0));
        chk("arst_mat_y", 64'(mat_y), 64'(0));
        chk("arst_valid", 64'(mat_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_overrun", 64'(overrun), 64'(0));
        chk("arst_state", 64'(dut.state), 64'(ST_IDLE));
        tick();
        rst_n     = 1'b1;
        load_en   = 1'b1;
        data_in_x = 1'b1;
        data_in_y = 1'b1;
        repeat (5) tick();
        load_en = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_cnt", 64'(dut.cnt), 64'(0));
        chk("post_rst_mat_x", 64'(mat_x), 64'(0));
        pulse_init();
        load_and_check("post_rst", x0, y0, 0);

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
